// File: rtl/gpu_mem_serializer.sv
// Serializes a per-lane warp memory request onto a single-port memory, one lane per access.
// Optional MEM_SER_COALESCE_EN: a load ack also fills every pending lane with the same address.
module gpu_mem_serializer #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_we,
  input  logic [NUM_THREADS-1:0]                  req_mask,
  input  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic                                    resp_valid,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  resp_rdata,
  output logic                                    mem_req,
  output logic                                    mem_we,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  output logic [DATA_WIDTH-1:0]                   mem_wdata,
  input  logic                                    mem_ack,
  input  logic [DATA_WIDTH-1:0]                   mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // REQ   | presenting the lowest pending lane to memory
  // RESP  | one-cycle resp_valid pulse
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  state_t                                  state;
  logic                                    we_q;
  logic [NUM_THREADS-1:0]                  pending;
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0]  addr_q;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  wdata_q;

  logic [NUM_THREADS-1:0] served;
  logic [NUM_THREADS-1:0] remaining;
  logic [IDX_W-1:0]       nxt_idx;
  logic [IDX_W-1:0]       acc_idx;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_THREADS-1:0] m);
    lowest = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--)
      if (m[i]) lowest = IDX_W'(i);
  endfunction

  always_comb begin
    served = '0;
    served[lowest(pending)] = 1'b1;
`ifdef MEM_SER_COALESCE_EN
    // Loads may satisfy every pending lane aimed at the address just returned.
    if (!we_q) begin
      for (int i = 0; i < NUM_THREADS; i++)
        if (pending[i] && (addr_q[i] == mem_addr)) served[i] = 1'b1;
    end
`else
`endif
    remaining = pending & ~served;
    nxt_idx   = lowest(remaining);
    acc_idx   = lowest(req_mask);
  end

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      pending    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            pending    <= req_mask;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            if (req_mask != '0) begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr[acc_idx];
              mem_wdata <= req_wdata[acc_idx];
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            pending <= remaining;
            if (!we_q) begin
              for (int i = 0; i < NUM_THREADS; i++)
                if (served[i]) resp_rdata[i] <= mem_rdata;
            end
            if (remaining == '0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              mem_wdata  <= '0;
            end else begin
              mem_addr  <= addr_q[nxt_idx];
              mem_wdata <= wdata_q[nxt_idx];
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_mem_serializer.sv
// Directed bench for gpu_mem_serializer with a configurable-latency memory model.
module tb_gpu_mem_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;
`ifdef MEM_SER_COALESCE_EN
  localparam int COAL_ACC = 1;
  localparam int COAL_LAT = 2;
`else
  localparam int COAL_ACC = 4;
  localparam int COAL_LAT = 5;
`endif

  logic                   clk;
  logic                   rst;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [N-1:0]           req_mask;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic                   resp_valid;
  logic [N-1:0][DW-1:0]   resp_rdata;
  logic                   mem_req;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_ack;
  logic [DW-1:0]          mem_rdata;

  int checks   = 0;
  int failures = 0;

  // memory model controls and access log
  int            ack_delay = 0;
  logic          fixed_en  = 1'b0;
  logic [DW-1:0] fixed_val = '0;
  int            wait_cnt  = 0;
  int            acc_cnt   = 0;
  logic [AW-1:0] log_addr  [64];
  logic [DW-1:0] log_wdata [64];
  logic          log_we    [64];

  gpu_mem_serializer #(.NUM_THREADS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = fixed_en ? fixed_val : mem_addr + 16'd10;

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
    if (!rst && mem_req && mem_ack) begin
      if (acc_cnt < 64) begin
        log_addr[acc_cnt]  <= mem_addr;
        log_wdata[acc_cnt] <= mem_wdata;
        log_we[acc_cnt]    <= mem_we;
      end
      acc_cnt <= acc_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and return edges from accept until resp_valid is seen (-1 on timeout).
  task automatic do_req(input logic we, input logic [N-1:0] mask,
                        input logic [N-1:0][AW-1:0] addr, input logic [N-1:0][DW-1:0] wdata,
                        output int lat);
    @(negedge clk);
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_mask = mask; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_mask = '1; req_addr = '1; req_wdata = '1; req_we = ~we;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 60) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!resp_valid) lat = -1;
    @(negedge clk);
    check("resp_pulse_one_cycle", {31'd0, resp_valid}, 32'd0);
  endtask

  int                  lat;
  int                  base;
  int                  cnt;
  int                  seen;
  logic [N-1:0][AW-1:0] a;
  logic [N-1:0][DW-1:0] w;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mask = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_rdata_lane0", {16'd0, resp_rdata[0]}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // load, all lanes, zero-wait
    a = {16'd3, 16'd2, 16'd1, 16'd0}; w = '0;
    base = acc_cnt;
    do_req(1'b0, 4'b1111, a, w, lat);
    check("t1_latency", lat, 32'd5);
    check("t1_accesses", acc_cnt - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", {16'd0, log_addr[base+i]}, i);
      check("t1_we", {31'd0, log_we[base+i]}, 32'd0);
      check("t1_rdata", {16'd0, resp_rdata[i]}, 10 + i);
    end

    // single lane load
    fixed_en = 1'b1; fixed_val = 16'h00AA;
    a = {16'd0, 16'd0, 16'd7, 16'd0};
    base = acc_cnt;
    do_req(1'b0, 4'b0010, a, w, lat);
    check("t2_latency", lat, 32'd2);
    check("t2_accesses", acc_cnt - base, 32'd1);
    check("t2_addr", {16'd0, log_addr[base]}, 32'd7);
    check("t2_rdata0", {16'd0, resp_rdata[0]}, 32'd0);
    check("t2_rdata1", {16'd0, resp_rdata[1]}, 32'h00AA);
    check("t2_rdata2", {16'd0, resp_rdata[2]}, 32'd0);
    check("t2_rdata3", {16'd0, resp_rdata[3]}, 32'd0);

    // store, lanes 0 and 3
    a = {16'd23, 16'd98, 16'd99, 16'd20}; w = {16'd8, 16'd66, 16'd77, 16'd5};
    base = acc_cnt;
    do_req(1'b1, 4'b1001, a, w, lat);
    check("t3_latency", lat, 32'd3);
    check("t3_accesses", acc_cnt - base, 32'd2);
    check("t3_addr0", {16'd0, log_addr[base]}, 32'd20);
    check("t3_data0", {16'd0, log_wdata[base]}, 32'd5);
    check("t3_we0", {31'd0, log_we[base]}, 32'd1);
    check("t3_addr1", {16'd0, log_addr[base+1]}, 32'd23);
    check("t3_data1", {16'd0, log_wdata[base+1]}, 32'd8);
    check("t3_we1", {31'd0, log_we[base+1]}, 32'd1);
    check("t3_rdata_zero", resp_rdata[1:0], 32'd0);
    check("t3_rdata_zero_hi", resp_rdata[3:2], 32'd0);

    // empty mask
    base = acc_cnt;
    do_req(1'b0, 4'b0000, a, w, lat);
    check("t4_latency", lat, 32'd1);
    check("t4_accesses", acc_cnt - base, 32'd0);

    // same address in every lane
    fixed_val = 16'h1234;
    a = {16'd4, 16'd4, 16'd4, 16'd4}; w = '0;
    base = acc_cnt;
    do_req(1'b0, 4'b1111, a, w, lat);
    check("t5_latency", lat, COAL_LAT);
    check("t5_accesses", acc_cnt - base, COAL_ACC);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check("t5_rdata_hold", {16'd0, resp_rdata[i]}, 32'h1234);

    // reset during the second of four slow accesses
    fixed_en = 1'b0; ack_delay = 3;
    base = acc_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_mask = 4'b1111; req_addr = {16'd3, 16'd2, 16'd1, 16'd0};
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt = 0;
    while (acc_cnt != base + 1 && cnt < 50) begin @(negedge clk); cnt++; end
    check("t6_first_access", acc_cnt - base, 32'd1);
    @(negedge clk);
    check("t6_busy_req", {31'd0, mem_req}, 32'd1);
    check("t6_busy_addr", {16'd0, mem_addr}, 32'd1);
    check("t6_busy_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("t6_rst_ready", {31'd0, req_ready}, 32'd1);
    check("t6_rst_rdata0", {16'd0, resp_rdata[0]}, 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (resp_valid || mem_req) seen++; end
    check("t6_no_resp_or_req", seen, 32'd0);
    check("t6_no_more_access", acc_cnt - base, 32'd1);

    // normal operation after abort
    ack_delay = 0;
    a = {16'd0, 16'd0, 16'd0, 16'd5};
    base = acc_cnt;
    do_req(1'b0, 4'b0001, a, w, lat);
    check("t7_latency", lat, 32'd2);
    check("t7_rdata0", {16'd0, resp_rdata[0]}, 32'd15);
    check("t7_rdata1", {16'd0, resp_rdata[1]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
